barrel_spawner: RTL and testbench

Upstream scheduler for the horizontal barrel movers. It owns N barrel slots, each wired to one barrel-mover instance. It issues single-cycle start pulses at pseudo-random intervals while the game is enabled, using round-robin slot allocation. It tracks which slots are in flight via each mover's done output, and drives the donkey throw-animation trigger.

---
 rtl/donkey_pkg.sv | 27 ++
 rtl/barrel_spawner_lfsr16.sv | 36 +++
 rtl/barrel_spawner.sv | 186 ++++++++++++++++++
 tb/tb_barrel_spawner.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/donkey_pkg.sv
// Shared types and constants for the donkey / barrel gameplay blocks.
package donkey_pkg;

    // Barrel spawner scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SELECT = 2'd2,
        ST_LAUNCH = 2'd3
    } spawn_state_e;

    // Default launch spacing: base gap plus a random number of steps.
    localparam logic [31:0] BARREL_GAP_MIN  = 32'd65_000_000;
    localparam logic [31:0] BARREL_GAP_STEP = 32'd8_125_000;

    // Default LFSR reset value; any non-zero value is legal.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // One step of the 16-bit Fibonacci LFSR, taps 16,15,13,4, shifting left
    // with the feedback bit entering at bit 0.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        logic fb;
        fb = cur[15] ^ cur[14] ^ cur[12] ^ cur[3];
        return {cur[14:0], fb};
    endfunction

endpackage

// File: rtl/barrel_spawner_lfsr16.sv
// Free-running 16-bit LFSR used as a random source for gameplay events.
module lfsr16 #(
    parameter logic [15:0] SEED = donkey_pkg::LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr_out
);
    import donkey_pkg::*;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next value: advance every cycle; recover to the seed if the register
    // ever held the lock-up value of all zeros.
    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_q == 16'h0000) begin
            lfsr_d = SEED;
        end else begin
            lfsr_d = lfsr16_next(lfsr_q);
        end
    end

    // LFSR register with synchronous reset to the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/barrel_spawner.sv
// Barrel spawner: launches barrels into free mover slots at random intervals
// with round-robin slot allocation, tracks in-flight slots via the movers'
// done edges and fires the donkey throw animation with every launch.
module barrel_spawner #(
    parameter int          N_BARRELS = 4,
    parameter logic [31:0] GAP_MIN   = donkey_pkg::BARREL_GAP_MIN,
    parameter logic [31:0] GAP_STEP  = donkey_pkg::BARREL_GAP_STEP,
    parameter int          RAND_BITS = 3,
    parameter logic [15:0] LFSR_SEED = donkey_pkg::LFSR_SEED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 game_en,
    input  logic [N_BARRELS-1:0] done,
    output logic [N_BARRELS-1:0] barrel,
    output logic [N_BARRELS-1:0] busy,
    output logic                 throw,
    output logic [7:0]           launch_cnt
);
    import donkey_pkg::*;

    localparam int PTR_W = (N_BARRELS > 1) ? $clog2(N_BARRELS) : 1;
    localparam logic [N_BARRELS-1:0] ONE_HOT_0 = {{(N_BARRELS-1){1'b0}}, 1'b1};

    // Scheduler state and datapath registers.
    spawn_state_e         state_q,      state_d;
    logic [31:0]          gap_q,        gap_d;
    logic [PTR_W-1:0]     rr_ptr_q,     rr_ptr_d;
    logic [PTR_W-1:0]     sel_q,        sel_d;
    logic [N_BARRELS-1:0] done_dly_q,   done_dly_d;
    logic [N_BARRELS-1:0] busy_q,       busy_d;
    logic [N_BARRELS-1:0] barrel_q,     barrel_d;
    logic                 throw_q,      throw_d;
    logic [7:0]           launch_cnt_q, launch_cnt_d;

    // Combinational helpers.
    logic [15:0]          lfsr_s;
    logic [31:0]          gap_load_s;
    logic                 found_s;
    logic [PTR_W-1:0]     found_idx_s;
    logic [N_BARRELS-1:0] freed_s;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .lfsr_out(lfsr_s)
    );

    // Fresh random gap, drawn from the low LFSR bits of the current cycle.
    assign gap_load_s = GAP_MIN + (32'(lfsr_s[RAND_BITS-1:0]) * GAP_STEP);

    // A slot frees on the rising edge of its done; edges on idle slots are
    // dropped so a stuck-high or spurious done cannot corrupt busy.
    assign freed_s = done & ~done_dly_q & busy_q;

    // Round-robin search starting at rr_ptr for the first slot not in flight.
    always_comb begin
        int idx;
        idx         = 0;
        found_s     = 1'b0;
        found_idx_s = '0;
        for (int i = 0; i < N_BARRELS; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_BARRELS;
            if (!found_s && !busy_q[idx]) begin
                found_s     = 1'b1;
                found_idx_s = PTR_W'(idx);
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Next-state logic: idle -> gap wait -> slot select -> one-cycle launch.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (game_en) begin
                    gap_d   = gap_load_s;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Leave once this decrement brings the counter to zero.
                if (!game_en) begin
                    state_d = ST_IDLE;
                end else if (gap_q <= 32'd1) begin
                    gap_d   = 32'd0;
                    state_d = ST_SELECT;
                end else begin
                    gap_d   = gap_q - 32'd1;
                end
            end
            ST_SELECT: begin
                // With every slot busy, keep re-checking; no new gap is drawn.
                if (!game_en) begin
                    state_d = ST_IDLE;
                end else if (found_s) begin
                    sel_d   = found_idx_s;
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_SELECT;
                end
            end
            ST_LAUNCH: begin
                gap_d   = gap_load_s;
                if (game_en) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and bookkeeping logic: start pulses are registered together with
    // the move into ST_LAUNCH, so they are high exactly while in ST_LAUNCH.
    always_comb begin
        done_dly_d   = done;
        busy_d       = busy_q & ~freed_s;
        rr_ptr_d     = rr_ptr_q;
        launch_cnt_d = launch_cnt_q;
        barrel_d     = '0;
        throw_d      = 1'b0;

        if (state_q == ST_LAUNCH) begin
            busy_d       = busy_d | (ONE_HOT_0 << sel_q);
            launch_cnt_d = launch_cnt_q + 8'd1;
            if (int'(sel_q) == (N_BARRELS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = sel_q + PTR_W'(1);
            end
        end else begin
            rr_ptr_d     = rr_ptr_q;
        end

        if (state_d == ST_LAUNCH) begin
            barrel_d = ONE_HOT_0 << sel_d;
            throw_d  = 1'b1;
        end else begin
            barrel_d = '0;
            throw_d  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gap_q        <= 32'd0;
            rr_ptr_q     <= '0;
            sel_q        <= '0;
            done_dly_q   <= '0;
            busy_q       <= '0;
            barrel_q     <= '0;
            throw_q      <= 1'b0;
            launch_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            rr_ptr_q     <= rr_ptr_d;
            sel_q        <= sel_d;
            done_dly_q   <= done_dly_d;
            busy_q       <= busy_d;
            barrel_q     <= barrel_d;
            throw_q      <= throw_d;
            launch_cnt_q <= launch_cnt_d;
        end
    end

    assign barrel     = barrel_q;
    assign busy       = busy_q;
    assign throw      = throw_q;
    assign launch_cnt = launch_cnt_q;

endmodule

// File: tb/tb_barrel_spawner.sv
// Bench for barrel_spawner: directed scenarios plus randomized mover returns,
// all checked every cycle against a timestamp-based behavioural model.
module tb_barrel_spawner;

    localparam int          N     = 4;
    localparam logic [31:0] GMIN  = 32'd10;
    localparam logic [31:0] GSTEP = 32'd1;
    localparam int          RB    = 2;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_en = 1'b0;
    logic [3:0] done = 4'b0000;
    logic [3:0] barrel;
    logic [3:0] busy;
    logic       throw;
    logic [7:0] launch_cnt;

    always #5 clk = ~clk;

    barrel_spawner #(
        .N_BARRELS(N),
        .GAP_MIN  (GMIN),
        .GAP_STEP (GSTEP),
        .RAND_BITS(RB),
        .LFSR_SEED(SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .game_en   (game_en),
        .done      (done),
        .barrel    (barrel),
        .busy      (busy),
        .throw     (throw),
        .launch_cnt(launch_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: outputs for the current cycle plus the time at which
    // the next slot search may begin.
    logic [3:0]  m_barrel;
    logic [3:0]  m_busy;
    logic        m_throw;
    logic [7:0]  m_cnt;
    logic [15:0] m_lfsr;
    logic [3:0]  m_done_prev;
    int          m_rr;
    bit          m_armed;
    longint      m_t;
    longint      m_sel_from;

    // Pulse bookkeeping observed on the DUT.
    int          pulse_cnt = 0;
    logic [3:0]  last_pulse = 4'b0000;
    longint      pulse_t[$];
    logic [3:0]  pulse_v[$];

    // Mover stand-ins for the random phase.
    bit          auto_ret = 1'b0;
    int          ret[4];

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, m_t, act, exp);
        end
    endtask

    task automatic model_reset();
        m_barrel    = 4'b0000;
        m_busy      = 4'b0000;
        m_throw     = 1'b0;
        m_cnt       = 8'd0;
        m_lfsr      = SEED;
        m_done_prev = 4'b0000;
        m_rr        = 0;
        m_armed     = 1'b0;
        m_sel_from  = 0;
    endtask

    // Predict the outputs of the next cycle from the inputs now applied.
    task automatic model_step();
        logic [3:0] freed;
        logic [3:0] nb;
        int         g;
        int         idx;
        int         sel;
        if (rst) begin
            model_reset();
            m_t++;
            return;
        end
        freed = done & ~m_done_prev & m_busy;
        nb    = 4'b0000;
        g     = int'(GMIN) + int'(m_lfsr[RB-1:0]) * int'(GSTEP);
        sel   = 0;
        if (m_barrel != 4'b0000) begin
            for (int i = 0; i < N; i++) if (m_barrel[i]) sel = i;
            m_busy = (m_busy & ~freed) | m_barrel;
            m_cnt  = m_cnt + 8'd1;
            m_rr   = (sel + 1) % N;
            m_armed    = game_en;
            m_sel_from = m_t + g + 1;
        end else begin
            if (!m_armed) begin
                if (game_en) begin
                    m_armed    = 1'b1;
                    m_sel_from = m_t + g + 1;
                end
            end else if (!game_en) begin
                m_armed = 1'b0;
            end else if (m_t >= m_sel_from) begin
                for (int i = 0; i < N; i++) begin
                    idx = (m_rr + i) % N;
                    if (nb == 4'b0000 && !m_busy[idx]) nb[idx] = 1'b1;
                end
            end
            m_busy = m_busy & ~freed;
        end
        m_lfsr      = lfsr_step(m_lfsr);
        m_done_prev = done;
        m_barrel    = nb;
        m_throw     = (nb != 4'b0000);
        m_t++;
    endtask

    task automatic compare_all();
        check("barrel", 32'(barrel), 32'(m_barrel));
        check("busy", 32'(busy), 32'(m_busy));
        check("throw", 32'(throw), 32'(m_throw));
        check("launch_cnt", 32'(launch_cnt), 32'(m_cnt));
        check("lfsr", 32'(dut.lfsr_s), 32'(m_lfsr));
        if (barrel !== 4'b0000) begin
            pulse_cnt++;
            last_pulse = barrel;
            pulse_t.push_back(m_t);
            pulse_v.push_back(barrel);
        end
    endtask

    // One clock: update movers, step the model, then sample on the falling edge.
    task automatic tick();
        if (auto_ret) begin
            for (int i = 0; i < N; i++) begin
                done[i] = 1'b0;
                if (ret[i] > 0) begin
                    ret[i]--;
                    if (ret[i] == 0) done[i] = 1'b1;
                end
                if (barrel[i] === 1'b1) ret[i] = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 63) == 0) begin
                int j;
                j = $urandom_range(0, 3);
                done[j] = 1'b1;
            end
        end
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_pulse(input int bound, input string name, output int n);
        int start;
        start = pulse_cnt;
        n = 0;
        while (pulse_cnt == start && n < bound) begin
            tick();
            n++;
        end
        if (pulse_cnt == start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no barrel pulse within %0d cycles", name, bound);
        end
    endtask

    initial begin
        int n;
        int quiet;
        longint sp;
        model_reset();
        m_t = 0;

        // 1: reset, then launches into the four empty slots in order.
        rst = 1'b1;
        repeat (5) tick();
        check("rst_barrel", 32'(barrel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cnt", 32'(launch_cnt), 32'h0);
        check("rst_lfsr", 32'(dut.lfsr_s), 32'hACE1);
        rst = 1'b0;
        game_en = 1'b1;
        tick();
        check("lfsr_first_step", 32'(dut.lfsr_s), 32'h59C3);
        for (int k = 0; k < 4; k++) wait_pulse(40, "first_four", n);
        if (pulse_v.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check("rr_order", 32'(pulse_v[k]), 32'(1) << k);
                if (k > 0) begin
                    sp = pulse_t[k] - pulse_t[k-1];
                    check("spacing_12_15", 32'(sp >= 12 && sp <= 15), 32'd1);
                end
            end
        end
        tick();
        check("busy_full", 32'(busy), 32'hF);
        check("cnt_four", 32'(launch_cnt), 32'd4);

        // 2: all slots busy; freeing slot 1 launches it without a gap.
        repeat (100) tick();
        done = 4'b0010;
        tick();
        done = 4'b0000;
        check("busy1_cleared", 32'(busy), 32'hD);
        n = 1;
        if (barrel === 4'b0000) begin
            wait_pulse(5, "refill", quiet);
            n = n + quiet;
        end
        check("refill_latency", 32'(n), 32'd2);
        check("refill_slot", 32'(last_pulse), 32'h2);
        tick();
        check("cnt_five", 32'(launch_cnt), 32'd5);

        // 3: disable during the gap wait; nothing launches, busy holds.
        repeat (3) tick();
        game_en = 1'b0;
        quiet = pulse_cnt;
        repeat (200) tick();
        check("no_pulse_disabled", 32'(pulse_cnt - quiet), 32'd0);
        check("busy_held", 32'(busy), 32'hF);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        tick();
        game_en = 1'b1;
        wait_pulse(40, "reenable", n);
        check("reenable_12_15", 32'(n >= 12 && n <= 15), 32'd1);
        check("reenable_slot", 32'(last_pulse), 32'h1);
        tick();

        // 4: done held high frees once; a held done on an idle slot is ignored.
        game_en = 1'b0;
        tick();
        done = 4'b0100;
        repeat (5) tick();
        check("single_free", 32'(busy), 32'hB);
        done = 4'b0000;
        tick();
        done = 4'b0100;
        repeat (5) tick();
        check("idle_done_ignored", 32'(busy), 32'hB);
        done = 4'b0000;
        tick();

        // 5: random mover returns until 260 launches, forcing the counter wrap.
        for (int i = 0; i < N; i++) ret[i] = busy[i] ? $urandom_range(1, 5) : 0;
        auto_ret = 1'b1;
        n = 0;
        while (pulse_cnt < 260 && n < 20000) begin
            game_en = ($urandom_range(0, 99) != 0);
            tick();
            n++;
        end
        game_en = 1'b1;
        check("reached_260", 32'(pulse_cnt >= 260), 32'd1);
        tick();
        check("cnt_wrap", 32'(launch_cnt), 32'd4);

        // 6: reset asserted while a barrel pulse is high.
        wait_pulse(100, "pre_reset", n);
        rst = 1'b1;
        tick();
        check("rst_mid_barrel", 32'(barrel), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_throw", 32'(throw), 32'h0);
        check("rst_mid_cnt", 32'(launch_cnt), 32'h0);
        check("rst_mid_lfsr", 32'(dut.lfsr_s), 32'hACE1);
        rst = 1'b0;
        auto_ret = 1'b0;
        done = 4'b0000;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
